// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine over a 128-bit state.
// Defining MIXCOL_BYPASS_EN adds i_bypass for a final-round pass-through.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_inverse,
`ifdef MIXCOL_BYPASS_EN
    input  logic         i_bypass,
`endif
    input  logic [127:0] i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state
);
    localparam int ITER = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(ITER - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic         inv;
    logic         byp;
    logic [1:0]   cnt;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using the x, 2x, 4x, 8x ladder
    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (m[0] ? x  : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [7:0] row(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c,
                                       input logic [7:0] d,
                                       input logic       iv);
        return gmul(a, iv ? 4'he : 4'h2) ^ gmul(b, iv ? 4'hb : 4'h3) ^
               gmul(c, iv ? 4'hd : 4'h1) ^ gmul(d, iv ? 4'h9 : 4'h1);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c,
                                        input logic        iv);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {row(s0, s1, s2, s3, iv), row(s1, s2, s3, s0, iv),
                row(s2, s3, s0, s1, iv), row(s3, s0, s1, s2, iv)};
    endfunction

    for (genvar j = 0; j < 4; j++) begin : g_col
        localparam logic [1:0] GRP = 2'(j / COLS_PER_CYCLE);
        assign st_nxt[32*j +: 32] = (cnt == GRP && !byp)
                                  ? mix(st[32*j +: 32], inv)
                                  : st[32*j +: 32];
    end

`ifdef MIXCOL_BYPASS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            byp <= 1'b0;
        else if (state == IDLE && i_valid)
            byp <= i_bypass;
    end
`else
    assign byp = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            st      <= '0;
            inv     <= 1'b0;
            cnt     <= 2'd0;
            o_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (i_valid) begin
                    st    <= i_state;
                    inv   <= i_inverse;
                    cnt   <= 2'd0;
                    state <= BUSY;
                end
                BUSY: begin
                    st <= st_nxt;
                    if (cnt == LAST) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: if (i_ready) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_state = st;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed and streaming checks for mix_columns_engine at 1, 2 and 4
// columns per cycle; the CPC=1 instance carries the detailed checks.
module tb_mix_columns_engine;
    localparam logic [127:0] PT  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] MC  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FI  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FO  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] BYP = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_inverse;
    logic         i_ready;
    logic [127:0] i_state;
`ifdef MIXCOL_BYPASS_EN
    logic         i_bypass;
`endif
    logic         rdy1, vld1, rdy2, vld2, rdy4, vld4;
    logic [127:0] st1, st2, st4;

    int n_chk = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy1),
        .i_inverse(i_inverse),
`ifdef MIXCOL_BYPASS_EN
        .i_bypass(i_bypass),
`endif
        .i_state(i_state), .o_valid(vld1), .i_ready(i_ready),
        .o_state(st1));

    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy2),
        .i_inverse(i_inverse),
`ifdef MIXCOL_BYPASS_EN
        .i_bypass(i_bypass),
`endif
        .i_state(i_state), .o_valid(vld2), .i_ready(i_ready),
        .o_state(st2));

    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(rdy4),
        .i_inverse(i_inverse),
`ifdef MIXCOL_BYPASS_EN
        .i_bypass(i_bypass),
`endif
        .i_state(i_state), .o_valid(vld4), .i_ready(i_ready),
        .o_state(st4));

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of the RTL ladder
    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s,
                                           input logic inv);
        logic [7:0] k[4];
        logic [7:0] b[4];
        logic [7:0] o;
        logic [127:0] r;
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 4; n++)
                b[n] = s[32*c + 31 - 8*n -: 8];
            for (int w = 0; w < 4; w++) begin
                o = 8'h00;
                for (int n = 0; n < 4; n++)
                    o = o ^ gm(b[(w + n) % 4], k[n]);
                r[32*c + 31 - 8*w -: 8] = o;
            end
        end
        return r;
    endfunction

    // Called at a negedge; returns result and clocks from accept to o_valid
    task automatic xact(input logic [127:0] s, input logic inv,
                        output logic [127:0] r, output int lat);
        logic took;
        int n;
        i_state   = s;
        i_inverse = inv;
        i_valid   = 1'b1;
        i_ready   = 1'b1;
        n = 0;
        do begin
            took = rdy1;
            @(negedge clk);
            n++;
        end while (!took && n < 50);
        chk("accept", 128'(took), 128'(1));
        i_valid = 1'b0;
        lat = 0;
        while (!vld1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = st1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] r, r2, s;
        int lat, l1, l2, l4, got, seen;

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_inverse = 1'b0;
        i_ready   = 1'b0;
        i_state   = '0;
`ifdef MIXCOL_BYPASS_EN
        i_bypass  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", 128'(vld1), 128'(0));
        chk("rst_state", st1, 128'(0));
        chk("rst_ready", 128'(rdy1), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Forward vector on all three widths, held in DONE by i_ready=0
        i_state = PT;
        i_valid = 1'b1;
        chk("ready_all", 128'({rdy1, rdy2, rdy4}), 128'(3'b111));
        @(negedge clk);
        i_valid = 1'b0;
        l1 = -1; l2 = -1; l4 = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (vld1 && l1 < 0) l1 = k;
            if (vld2 && l2 < 0) l2 = k;
            if (vld4 && l4 < 0) l4 = k;
        end
        chk("lat_cpc1", 128'(l1), 128'(4));
        chk("lat_cpc2", 128'(l2), 128'(2));
        chk("lat_cpc4", 128'(l4), 128'(1));
        chk("fwd_cpc1", st1, MC);
        chk("fwd_cpc2", st2, MC);
        chk("fwd_cpc4", st4, MC);

        // Back-pressure: five more clocks held in DONE
        i_state   = FI;
        i_inverse = 1'b1;
        i_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 128'(vld1), 128'(1));
            chk("bp_state", st1, MC);
            chk("bp_ready", 128'(rdy1), 128'(0));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 128'(vld1), 128'(0));
        chk("bp_rel_ready", 128'(rdy1), 128'(1));

        xact(MC, 1'b1, r, lat);
        chk("inv_vec", r, PT);
        chk("inv_lat", 128'(lat), 128'(4));
        xact(FI, 1'b0, r, lat);
        chk("fips_fwd", r, FO);
        xact(FO, 1'b1, r, lat);
        chk("fips_inv", r, FI);

        for (int t = 0; t < 3; t++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            xact(s, 1'b0, r, lat);
            chk("rt_fwd", r, model(s, 1'b0));
            xact(r, 1'b1, r2, lat);
            chk("rt_inv", r2, s);
        end

        // Streaming with i_valid held high between transactions
        got = 0;
        i_ready = 1'b1;
        fork
            begin
                logic took;
                int n;
                for (int t = 0; t < 100; t++) begin
                    i_state   = {$urandom, $urandom, $urandom, $urandom};
                    i_inverse = 1'($urandom_range(0, 1));
                    i_valid   = 1'b1;
                    n = 0;
                    do begin
                        took = rdy1;
                        @(negedge clk);
                        n++;
                    end while (!took && n < 50);
                    if (took) exp_q.push_back(model(i_state, i_inverse));
                    else chk("stream_accept", 128'(took), 128'(1));
                end
                i_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 100 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (vld1) begin
                        if (exp_q.size() == 0)
                            chk("stream_extra", 128'(1), 128'(0));
                        else
                            chk("stream", st1, exp_q.pop_front());
                        got++;
                    end
                end
            end
        join
        chk("stream_count", 128'(got), 128'(100));
        repeat (8) @(negedge clk);

        // Reset two clocks into BUSY
        i_state   = PT;
        i_inverse = 1'b0;
        i_valid   = 1'b1;
        chk("rb_ready", 128'(rdy1), 128'(1));
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rb_valid", 128'(vld1), 128'(0));
        chk("rb_state", st1, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rb_rel_ready", 128'(rdy1), 128'(1));
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (vld1) seen++;
        end
        chk("rb_no_stale", 128'(seen), 128'(0));

`ifdef MIXCOL_BYPASS_EN
        i_bypass = 1'b1;
        xact(BYP, 1'b0, r, lat);
        i_bypass = 1'b0;
        chk("byp_state", r, BYP);
        chk("byp_lat", 128'(lat), 128'(4));
        xact(BYP, 1'b0, r, lat);
        chk("byp_off", r, model(BYP, 1'b0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
